// File: rtl/vga_image_fetch.sv
// vga_image_fetch: 640x480@60 VGA timing from a 50 MHz clock, image-window address generation and registered RGB332 output.
// Optional VGA_BORDER_EN draws a one-pixel 8'hFF frame around the image window.
module vga_image_fetch #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          IMG_W     = 64,
    parameter int          IMG_H     = 64,
    parameter int          SCALE_SH  = 2,
    parameter int          IMG_X     = 192,
    parameter int          IMG_Y     = 112,
    parameter logic [7:0]  BG_COLOR  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] vgaAdress,
    input  logic [7:0]  ImageData,
    output logic [7:0]  vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_active,
    output logic        frame_start
);
    localparam logic [31:0] X0 = 32'(IMG_X);
    localparam logic [31:0] X1 = 32'(IMG_X + (IMG_W << SCALE_SH));
    localparam logic [31:0] Y0 = 32'(IMG_Y);
    localparam logic [31:0] Y1 = 32'(IMG_Y + (IMG_H << SCALE_SH));
    localparam logic [31:0] W  = 32'(IMG_W);

    logic        r_phase;
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic [31:0] r_addr;
    logic        r_win_d;
    logic        r_act_d;
    logic        r_hs_d;
    logic        r_vs_d;
    logic        r_zero_d;
    logic [7:0]  r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_act;
    logic        r_fs;
    logic        w_tick;
    logic        w_h_end;
    logic        w_v_end;
    logic        w_win;
    logic        w_act;
    logic        w_hs;
    logic        w_vs;
    logic        w_zero;
    logic [31:0] w_h;
    logic [31:0] w_v;
    logic [31:0] w_addr;
    logic [7:0]  w_rgb;

    assign w_tick  = r_phase;
    assign w_h_end = r_h == 10'd799;
    assign w_v_end = r_v == 10'd524;
    assign w_h     = 32'(r_h);
    assign w_v     = 32'(r_v);
    assign w_win   = w_h >= X0 && w_h < X1 && w_v >= Y0 && w_v < Y1;
    assign w_act   = r_h < 10'd640 && r_v < 10'd480;
    assign w_hs    = !(r_h >= 10'd656 && r_h <= 10'd751);
    assign w_vs    = !(r_v >= 10'd490 && r_v <= 10'd491);
    assign w_zero  = r_h == 10'd0 && r_v == 10'd0;
    assign w_addr  = w_win ? BASE_ADDR + ((w_v - Y0) >> SCALE_SH) * W + ((w_h - X0) >> SCALE_SH) : BASE_ADDR;

`ifdef VGA_BORDER_EN
    logic w_ring;
    logic r_ring_d;

    // +1 on the low-side compares avoids wrap when the window touches column/row 0
    assign w_ring = !w_win && w_h + 32'd1 >= X0 && w_h <= X1 && w_v + 32'd1 >= Y0 && w_v <= Y1;
    assign w_rgb  = !r_act_d ? 8'h00 : r_win_d ? ImageData : r_ring_d ? 8'hFF : BG_COLOR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ring_d <= 1'b0;
        end else if (w_tick) begin
            r_ring_d <= w_ring;
        end
    end
`else
    assign w_rgb = !r_act_d ? 8'h00 : r_win_d ? ImageData : BG_COLOR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= 1'b0;
            r_h      <= 10'd0;
            r_v      <= 10'd0;
            r_addr   <= BASE_ADDR;
            r_win_d  <= 1'b0;
            r_act_d  <= 1'b0;
            r_hs_d   <= 1'b1;
            r_vs_d   <= 1'b1;
            r_zero_d <= 1'b0;
            r_rgb    <= 8'h00;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_act    <= 1'b0;
            r_fs     <= 1'b0;
        end else begin
            r_phase <= !r_phase;
            r_fs    <= w_tick && r_zero_d;
            if (w_tick) begin
                r_h <= w_h_end ? 10'd0 : r_h + 10'd1;
                if (w_h_end)
                    r_v <= w_v_end ? 10'd0 : r_v + 10'd1;
                r_addr   <= w_addr;
                r_win_d  <= w_win;
                r_act_d  <= w_act;
                r_hs_d   <= w_hs;
                r_vs_d   <= w_vs;
                r_zero_d <= w_zero;
                r_rgb    <= w_rgb;
                r_hs     <= r_hs_d;
                r_vs     <= r_vs_d;
                r_act    <= r_act_d;
            end
        end
    end

    assign vgaAdress   = r_addr;
    assign vga_rgb     = r_rgb;
    assign vga_hsync   = r_hs;
    assign vga_vsync   = r_vs;
    assign vga_active  = r_act;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_image_fetch.sv
// tb_vga_image_fetch: table-driven pixel checks through a scoreboard, plus sync/frame_start/reset sequences.
// A short window (IMG_Y=2, IMG_H=8, SCALE_SH=1) keeps every checked pixel within the first 20 lines.
module tb_vga_image_fetch;
    localparam logic [31:0] BASE = 32'h100;
    localparam logic [7:0]  BG   = 8'h5A;
`ifdef VGA_BORDER_EN
    localparam logic [7:0]  BRD  = 8'hFF;
`else
    localparam logic [7:0]  BRD  = BG;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] vgaAdress;
    logic [7:0]  ImageData;
    logic [7:0]  vga_rgb;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_active;
    logic        frame_start;

    assign ImageData = vgaAdress[7:0] ^ 8'h3C;

    vga_image_fetch #(
        .BASE_ADDR(BASE), .IMG_W(64), .IMG_H(8), .SCALE_SH(1),
        .IMG_X(192), .IMG_Y(2), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vgaAdress(vgaAdress), .ImageData(ImageData),
        .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_active(vga_active), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        logic [31:0] addr;
        logic [7:0]  rgb;
        logic        act;
    } vec_t;
    typedef struct {
        int   n;
        vec_t e;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   passed = 0;
    int   total = 0;
    int   k;
    int   fs_cnt;
    int   fs_first;
    int   vs_low;
    int   hs_fall[$];
    int   hs_rise[$];
    logic prev_hs;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic add(input int h, input int v, input logic [31:0] a, input logic [7:0] r, input logic act);
        vec_t t;
        t.h = h;
        t.v = v;
        t.addr = a;
        t.rgb = r;
        t.act = act;
        tbl.push_back(t);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, vgaAdress, BASE);
        chk({tag, "_rgb"}, 32'(vga_rgb), 32'h0);
        chk({tag, "_hsync"}, 32'(vga_hsync), 32'h1);
        chk({tag, "_vsync"}, 32'(vga_vsync), 32'h1);
        chk({tag, "_active"}, 32'(vga_active), 32'h0);
        chk({tag, "_fs"}, 32'(frame_start), 32'h0);
    endtask

    task automatic clear_mon();
        k = 0;
        fs_cnt = 0;
        fs_first = -1;
        vs_low = 0;
        prev_hs = 1'b1;
        hs_fall.delete();
        hs_rise.delete();
        sb.delete();
    endtask

    // Beam n is registered into vgaAdress on edge 2n+2 and reaches the colour outputs on edge 2n+4.
    task automatic monitor();
        int  n;
        sb_t s;
        if (k >= 2 && k % 2 == 0) begin
            n = (k - 2) / 2;
            foreach (tbl[i]) begin
                if (tbl[i].v * 800 + tbl[i].h == n) begin
                    chk($sformatf("addr(%0d,%0d)", tbl[i].h, tbl[i].v), vgaAdress, tbl[i].addr);
                    s.n = n;
                    s.e = tbl[i];
                    sb.push_back(s);
                end
            end
        end
        if (k >= 4 && k % 2 == 0 && sb.size() > 0 && sb[0].n == (k - 4) / 2) begin
            s = sb.pop_front();
            chk($sformatf("rgb(%0d,%0d)", s.e.h, s.e.v), 32'(vga_rgb), 32'(s.e.rgb));
            chk($sformatf("active(%0d,%0d)", s.e.h, s.e.v), 32'(vga_active), 32'(s.e.act));
        end
        if (frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
        end
        if (prev_hs && !vga_hsync) hs_fall.push_back(k);
        if (!prev_hs && vga_hsync) hs_rise.push_back(k);
        prev_hs = vga_hsync;
        if (!vga_vsync) vs_low++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        monitor();
    endtask

    initial begin
        add(0, 0, BASE, BG, 1'b1);
        add(250, 1, BASE, BRD, 1'b1);
        add(190, 2, BASE, BG, 1'b1);
        add(191, 2, BASE, BRD, 1'b1);
        add(192, 2, 32'h100, 8'h3C, 1'b1);
        add(193, 2, 32'h100, 8'h3C, 1'b1);
        add(194, 2, 32'h101, 8'h3D, 1'b1);
        add(192, 4, 32'h140, 8'h7C, 1'b1);
        add(200, 5, 32'h144, 8'h78, 1'b1);
        add(639, 10, BASE, BG, 1'b1);
        add(640, 10, BASE, 8'h00, 1'b0);
        add(700, 10, BASE, 8'h00, 1'b0);
        add(319, 17, 32'h2FF, 8'hC3, 1'b1);
        add(320, 17, BASE, BRD, 1'b1);
        add(321, 17, BASE, BG, 1'b1);
        add(192, 18, BASE, BRD, 1'b1);
        add(192, 19, BASE, BG, 1'b1);

        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        while (k < 32602) step();

        // Beam now at (300,20); outputs show (299,20), a background pixel below the window.
        chk("pre_mid_rgb", 32'(vga_rgb), 32'(BG));
        chk("pre_mid_active", 32'(vga_active), 32'h1);
        chk("fs_first", fs_first, 4);
        chk("fs_count", fs_cnt, 1);
        chk("hs_fall0", hs_fall.size() > 0 ? hs_fall[0] : -1, 1316);
        chk("hs_rise0", hs_rise.size() > 0 ? hs_rise[0] : -1, 1508);
        chk("hs_fall1", hs_fall.size() > 1 ? hs_fall[1] : -1, 2916);
        chk("vs_low", vs_low, 0);
        chk("sb_drained", sb.size(), 0);

        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        @(posedge clk);
        #1;
        chk_reset("mid_hold");
        clear_mon();
        rst_n = 1'b1;
        while (k < 3000) step();
        chk("mid_fs_first", fs_first, 4);
        chk("mid_fs_count", fs_cnt, 1);
        chk("mid_hs_fall0", hs_fall.size() > 0 ? hs_fall[0] : -1, 1316);
        chk("mid_hs_rise0", hs_rise.size() > 0 ? hs_rise[0] : -1, 1508);
        chk("mid_hs_fall1", hs_fall.size() > 1 ? hs_fall[1] : -1, 2916);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_image_fetch.md
# vga_image_fetch

Display-side consumer of the data memory's VGA read port. Generates 640x480@60 Hz VGA timing from the 50 MHz system clock, converts the beam position into a byte address for the image stored in data memory, samples the returned pixel byte and drives registered RGB332 colour plus sync outputs. It sits directly downstream of the data memory: it drives `vgaAdress`, and it consumes `ImageData` combinationally on the same cycle.

## Interface
- `BASE_ADDR`, 0: data-memory byte address of image pixel (0,0).
- `IMG_W`, 64: image width in pixels.
- `IMG_H`, 64: image height in pixels.
- `SCALE_SH`, 2: log2 of the integer upscale factor. Each image pixel covers 2^SCALE_SH x 2^SCALE_SH screen pixels.
- `IMG_X`, 192: screen column of the image window's left edge.
- `IMG_Y`, 112: screen row of the image window's top edge.
- `BG_COLOR`, 8'h00: RGB332 colour driven inside the active area but outside the window.
- `clk` in 1: 50 MHz system clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `vgaAdress` out 32: registered byte address to the data memory VGA port.
- `ImageData` in 8: pixel byte returned combinationally for `vgaAdress`.
- `vga_rgb` out 8: RGB332 colour, as {R[2:0],G[2:0],B[1:0]}.
- `vga_hsync` out 1: horizontal sync, active low.
- `vga_vsync` out 1: vertical sync, active low.
- `vga_active` out 1: high while the registered outputs represent a visible pixel.
- `frame_start` out 1: one-`clk` pulse at the start of every frame.

## Operation
- **Pixel tick**
  - A 1-bit phase toggles every `clk`; `tick` = phase==1, giving 25 MHz.
  - Counters, address and outputs update only on `tick` cycles.
- **Horizontal counter `h_cnt`** (0..799)
  - Active 0–639, front porch 640–655, sync 656–751, back porch 752–799.
  - Wraps 799→0 and increments `v_cnt`.
- **Vertical counter `v_cnt`** (0..524)
  - Active 0–479, front porch 480–489, sync 490–491, back porch 492–524.
  - Wraps 524→0.
- **Stage 0 (address)**: on each tick, from the current (h,v):
  - `in_win` = h in [IMG_X, IMG_X+(IMG_W<<SCALE_SH)) and v in [IMG_Y, IMG_Y+(IMG_H<<SCALE_SH)).
  - If `in_win`, `vgaAdress` <= BASE_ADDR + ((v-IMG_Y)>>SCALE_SH)*IMG_W + ((h-IMG_X)>>SCALE_SH).
  - Otherwise `vgaAdress` <= BASE_ADDR.
  - Delayed copies of `in_win`, active (h<640 && v<480), the hsync term and the vsync term are registered alongside.
- **Stage 1 (colour)**: on the next tick:
  - `vga_rgb` <= `ImageData` if the delayed active and `in_win` are both set.
  - `vga_rgb` <= BG_COLOR if delayed active is set but delayed `in_win` is clear.
  - `vga_rgb` <= 0 during blanking.
  - Syncs and `vga_active` are taken from the delayed copies, so they stay aligned with colour.
- **Address arithmetic**
  - All address arithmetic is unsigned 32-bit.
  - The multiply uses constant IMG_W.
  - No bounds check against memory size: the integrator keeps BASE_ADDR+IMG_W*IMG_H ≤ memory depth.
- **`frame_start`**: high for exactly one `clk` on the tick where stage 1 outputs the data for (h,v)=(0,0).

## Timing
- **Reset values**
  - phase=0, `h_cnt`=0, `v_cnt`=0.
  - `vgaAdress`=BASE_ADDR, `vga_rgb`=0.
  - `vga_hsync`=1, `vga_vsync`=1.
  - `vga_active`=0, `frame_start`=0.
- **Latency**
  - Beam position to `vgaAdress`: 1 tick (2 `clk`).
  - Beam position to `vga_rgb`, syncs and `vga_active`: 2 ticks (4 `clk`). Constant.
- **Memory handshake**
  - `ImageData` must settle within one tick of `vgaAdress` changing.
  - `ImageData` is sampled on the tick after the address was registered.
  - A data-memory write to the displayed address takes effect in the next frame, or in the current frame if the beam has not yet reached that pixel.
- **Line and frame counts**
  - One line = 800 ticks = 1600 `clk`.
  - One frame = 525 lines = 840000 `clk`.
- **Reset mid-frame**
  - Outputs go to their reset values immediately.
  - After release, the first tick occurs on the second `clk`, and the frame restarts at (0,0).
  - `frame_start` pulses 4 `clk` after release.
- **Window edges**
  - The last window column is IMG_X+(IMG_W<<SCALE_SH)-1; the next column is background.
  - The bottom-right pixel maps to BASE_ADDR+IMG_W*IMG_H-1.

## Configuration
- **`VGA_BORDER_EN`**
  - Defined: pixels one screen pixel outside the window rectangle (columns IMG_X-1 and IMG_X+W, rows IMG_Y-1 and IMG_Y+H, within those spans) are forced to 8'hFF in stage 1. The address path is unchanged.
  - Undefined: those pixels show BG_COLOR.

## Test plan
- **Reset and first frame**: assert `rst_n`=0 for 3 `clk`, then release.
  - All outputs hold reset values during reset.
  - `frame_start` pulses at `clk` 4 after release.
  - Next `frame_start` comes exactly 840000 `clk` later.
- **Sync widths and positions**
  - `vga_hsync` low for 192 `clk`, starting 2 ticks after `h_cnt`=656.
  - `vga_vsync` low for exactly 2 lines (3200 `clk`).
- **Address mapping** (defaults, memory model returning addr[7:0]):
  - Screen (192,112) → `vgaAdress`=0, `vga_rgb`=8'h00.
  - (196,112) → 1.
  - (192,116) → 64.
  - (447,367) → 4095.
  - (448,367) → BASE_ADDR, `vga_rgb`=BG_COLOR.
- **Blanking**: at h=700 (in window rows), `vga_rgb`=0 and `vga_active`=0.
- **Mid-frame reset**: pulse `rst_n` low at v=200, h=300.
  - Outputs reset immediately.
  - Counters restart at (0,0) and `frame_start` follows after 4 `clk`.
- **`VGA_BORDER_EN` defined**: pixel (191,150) → 8'hFF; pixel (190,150) → BG_COLOR.
